dmem_store_buffer: RTL and testbench

Responder-side data-memory front end for the single-cycle core's load/store port. It accepts CPU stores in one cycle into a small FIFO and drains them to a slower backing data memory over a req/ack write handshake. Loads complete combinationally, with store-to-load forwarding from the buffer. It sits between the core's `load_en`/`l_*`/`store_en`/`s_*` port and the data memory, in place of a direct hookup.

---
 rtl/dmem_store_buffer_pkg.sv | 13 +
 rtl/sb_fifo_mem.sv | 76 +++++++
 rtl/dmem_store_buffer.sv | 121 ++++++++++++
 tb/tb_dmem_store_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// Shared word width, default buffer depth and drain-FSM encodings for the
// data-memory store buffer.
package dmem_store_buffer_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int SB_DEPTH   = 4;

   typedef enum logic {
      SB_IDLE = 1'b0,
      SB_BUSY = 1'b1
   } sb_state_e;

endpackage

// File: rtl/sb_fifo_mem.sv
// DEPTH-entry {addr, data} store FIFO. All entries and their valid bits are
// exposed so the parent can run a store-to-load forwarding match.
module sb_fifo_mem
   import dmem_store_buffer_pkg::*;
#(
   parameter int  W     = WORD_WIDTH,
   parameter int  DEPTH = SB_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_push,
   input  logic [W-1:0]            i_push_addr,
   input  logic [W-1:0]            i_push_data,
   input  logic                    i_pop,
   output logic [W-1:0]            o_head_addr,
   output logic [W-1:0]            o_head_data,
   output logic [DEPTH-1:0][W-1:0] o_ent_addr,
   output logic [DEPTH-1:0][W-1:0] o_ent_data,
   output logic [DEPTH-1:0]        o_ent_valid,
   output logic [AW-1:0]           o_tail,
   output logic [AW:0]             o_count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0]            r_head;
   logic [AW-1:0]            r_tail;
   logic [AW:0]              r_count;
   logic [DEPTH-1:0][W-1:0]  r_addr;
   logic [DEPTH-1:0][W-1:0]  r_data;
   logic [DEPTH-1:0]         r_valid;
   logic                     w_push;
   logic                     w_pop;

   assign w_push = i_push & (r_count != FULL_COUNT);
   assign w_pop  = i_pop & (r_count != {(AW+1){1'b0}});

   // Entry storage, pointers, occupancy and per-slot valid bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= '0;
      end else begin
         if (w_push) begin
            r_addr[r_tail]  <= i_push_addr;
            r_data[r_tail]  <= i_push_data;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + AW'(1'b1);
         end
         // Push and pop never target the same slot: that needs count 0 or DEPTH.
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + AW'(1'b1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1'b1);
            2'b01:   r_count <= r_count - (AW+1)'(1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_addr = r_addr[r_head];
   assign o_head_data = r_data[r_head];
   assign o_ent_addr  = r_addr;
   assign o_ent_data  = r_data;
   assign o_ent_valid = r_valid;
   assign o_tail      = r_tail;
   assign o_count     = r_count;

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the core's load/store port and a slower data memory:
// single-cycle store accept, req/ack drain, combinational forwarding loads.
module dmem_store_buffer
   import dmem_store_buffer_pkg::*;
#(
   parameter int W     = WORD_WIDTH,
   parameter int DEPTH = SB_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         store_en,
   input  logic [W-1:0] s_addr,
   input  logic [W-1:0] s_data,
   input  logic         load_en,
   input  logic [W-1:0] l_addr,
   output logic [W-1:0] l_data,
   output logic         stall,
   output logic         empty,
   output logic         mem_wr_req,
   output logic [W-1:0] mem_wr_addr,
   output logic [W-1:0] mem_wr_data,
   input  logic         mem_wr_ack,
   output logic [W-1:0] mem_rd_addr,
   input  logic [W-1:0] mem_rd_data
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   sb_state_e               r_state;
   logic                    w_full;
   logic                    w_push;
   logic                    w_pop;
   logic [W-1:0]            w_head_addr;
   logic [W-1:0]            w_head_data;
   logic [DEPTH-1:0][W-1:0] w_ent_addr;
   logic [DEPTH-1:0][W-1:0] w_ent_data;
   logic [DEPTH-1:0]        w_ent_valid;
   logic [AW-1:0]           w_tail;
   logic [AW:0]             w_count;
   logic [AW-1:0]           w_idx;
   logic                    w_hit;
   logic [W-1:0]            w_fwd_data;

   sb_fifo_mem #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_addr (s_addr),
      .i_push_data (s_data),
      .i_pop       (w_pop),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_ent_addr  (w_ent_addr),
      .o_ent_data  (w_ent_data),
      .o_ent_valid (w_ent_valid),
      .o_tail      (w_tail),
      .o_count     (w_count)
   );

   // A pop in the same cycle does not free space for a refused store.
   assign w_full      = (w_count == FULL_COUNT);
   assign stall       = store_en & w_full;
   assign w_push      = store_en & ~w_full;
   assign w_pop       = (r_state == SB_BUSY) & mem_wr_ack;
   assign empty       = (w_count == {(AW+1){1'b0}}) & (r_state == SB_IDLE);
   assign mem_rd_addr = l_addr;

   // Drain FSM: the in-flight entry stays buffered until acknowledged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= SB_IDLE;
         mem_wr_req  <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
      end else begin
         case (r_state)
            SB_IDLE: begin
               if (w_count != {(AW+1){1'b0}}) begin
                  mem_wr_addr <= w_head_addr;
                  mem_wr_data <= w_head_data;
                  mem_wr_req  <= 1'b1;
                  r_state     <= SB_BUSY;
               end
            end
            SB_BUSY: begin
               if (mem_wr_ack) begin
                  mem_wr_req <= 1'b0;
                  r_state    <= SB_IDLE;
               end
            end
            default: begin
               mem_wr_req <= 1'b0;
               r_state    <= SB_IDLE;
            end
         endcase
      end
   end

   // Forwarding mux: scan from tail-1 (youngest) back, first match wins.
   always_comb begin
      w_hit      = 1'b0;
      w_fwd_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = w_tail - AW'(k + 1);
         if (!w_hit && w_ent_valid[w_idx] && (w_ent_addr[w_idx] == l_addr)) begin
            w_hit      = 1'b1;
            w_fwd_data = w_ent_data[w_idx];
         end else begin
            w_fwd_data = w_fwd_data;
         end
      end
      if (load_en && w_hit) begin
         l_data = w_fwd_data;
      end else begin
         l_data = mem_rd_data;
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: reset, drain handshake, fill/stall,
// forwarding (incl. in-flight entry) and pointer wrap with random ack delays.
module tb_dmem_store_buffer;

   localparam int           W       = 32;
   localparam logic [W-1:0] MEM_KEY = 32'hA5A5_0000;

   logic         clk;
   logic         rst;
   logic         store_en;
   logic [W-1:0] s_addr;
   logic [W-1:0] s_data;
   logic         load_en;
   logic [W-1:0] l_addr;
   logic [W-1:0] l_data;
   logic         stall;
   logic         empty;
   logic         mem_wr_req;
   logic [W-1:0] mem_wr_addr;
   logic [W-1:0] mem_wr_data;
   logic         mem_wr_ack;
   logic [W-1:0] mem_rd_addr;
   logic [W-1:0] mem_rd_data;

   int           n_chk;
   int           n_fail;
   int           ack_mode;   // 0: manual (man_ack), 1: zero-wait, 2: random 0-3 wait
   logic         man_ack;
   logic         auto_ack;
   logic [W-1:0] wq_addr[$];
   logic [W-1:0] wq_data[$];

   dmem_store_buffer #(.W(W), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .store_en    (store_en),
      .s_addr      (s_addr),
      .s_data      (s_data),
      .load_en     (load_en),
      .l_addr      (l_addr),
      .l_data      (l_data),
      .stall       (stall),
      .empty       (empty),
      .mem_wr_req  (mem_wr_req),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_ack  (mem_wr_ack),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd_data = l_addr ^ MEM_KEY;
   assign mem_wr_ack  = (ack_mode == 0) ? man_ack : auto_ack;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Backing-memory write responder.
   initial begin : responder
      int dly;
      dly      = 0;
      auto_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_mode == 0) begin
            auto_ack = 1'b0;
            dly      = 0;
         end else if (mem_wr_req && !auto_ack) begin
            if (dly == 0) auto_ack = 1'b1;
            else dly--;
         end else begin
            auto_ack = 1'b0;
            dly      = (ack_mode == 2) ? int'($urandom_range(0, 3)) : 0;
         end
      end
   end

   // Record every accepted write.
   initial begin : monitor
      forever begin
         @(posedge clk);
         if (rst && mem_wr_req && mem_wr_ack) begin
            wq_addr.push_back(mem_wr_addr);
            wq_data.push_back(mem_wr_data);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int ws_i;
      int guard;
      n_chk = 0; n_fail = 0;
      rst = 1'b0; store_en = 1'b0; s_addr = '0; s_data = '0;
      load_en = 1'b0; l_addr = '0; man_ack = 1'b0; ack_mode = 0;

      // Reset state
      repeat (2) @(negedge clk);
      store_en = 1'b1;
      #1;
      chk("rst_req",   {31'd0, mem_wr_req}, 32'd0);
      chk("rst_empty", {31'd0, empty},      32'd1);
      chk("rst_stall", {31'd0, stall},      32'd0);
      chk("rst_waddr", mem_wr_addr,         32'd0);
      store_en = 1'b0;
      @(negedge clk); rst = 1'b1;

      // Single store, zero-wait ack
      ack_mode = 1;
      @(negedge clk);
      store_en = 1'b1; s_addr = 32'h10; s_data = 32'hDEAD_BEEF;
      #1 chk("t1_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      store_en = 1'b0; load_en = 1'b1; l_addr = 32'h10;
      #1;
      chk("t1_req_idle", {31'd0, mem_wr_req}, 32'd0);
      chk("t1_empty0",   {31'd0, empty},      32'd0);
      chk("t1_fwd",      l_data,              32'hDEAD_BEEF);
      chk("t1_rdaddr",   mem_rd_addr,         32'h10);
      @(negedge clk); #1;
      chk("t1_req",   {31'd0, mem_wr_req}, 32'd1);
      chk("t1_waddr", mem_wr_addr,         32'h10);
      chk("t1_wdata", mem_wr_data,         32'hDEAD_BEEF);
      @(negedge clk); #1;
      chk("t1_req_done", {31'd0, mem_wr_req}, 32'd0);
      chk("t1_empty1",   {31'd0, empty},      32'd1);
      chk("t1_nwr",      wq_addr.size(),      32'd1);
      chk("t1_mem_load", l_data,              32'h10 ^ MEM_KEY);
      load_en = 1'b0;

      // Fill and stall with ack held low
      ack_mode = 0; man_ack = 1'b0;
      wq_addr.delete(); wq_data.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         store_en = 1'b1; s_addr = W'(4 * i); s_data = 32'hF000_0000 | W'(i);
         #1 chk("t2_accept", {31'd0, stall}, 32'd0);
      end
      @(negedge clk);
      s_addr = 32'h10; s_data = 32'hF000_0004;
      #1;
      chk("t2_full_stall", {31'd0, stall},      32'd1);
      chk("t2_req_busy",   {31'd0, mem_wr_req}, 32'd1);
      chk("t2_head_addr",  mem_wr_addr,         32'h0);
      chk("t2_head_data",  mem_wr_data,         32'hF000_0000);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0; ack_mode = 1;
      #1;
      chk("t2_unstall", {31'd0, stall},      32'd0);
      chk("t2_req_pop", {31'd0, mem_wr_req}, 32'd0);
      @(negedge clk);
      store_en = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      chk("t2_empty", {31'd0, empty},  32'd1);
      chk("t2_nwr",   wq_addr.size(),  32'd5);
      for (int i = 0; i < 5 && i < wq_addr.size(); i++) begin
         chk("t2_order_addr", wq_addr[i], W'(4 * i));
         chk("t2_order_data", wq_data[i], 32'hF000_0000 | W'(i));
      end

      // Forwarding, including the in-flight entry
      ack_mode = 0; man_ack = 1'b0;
      wq_addr.delete(); wq_data.delete();
      @(negedge clk); store_en = 1'b1; s_addr = 32'h30; s_data = 32'h111;
      @(negedge clk); s_addr = 32'h20; s_data = 32'h1;
      @(negedge clk); s_addr = 32'h20; s_data = 32'h2;
      @(negedge clk);
      store_en = 1'b0; load_en = 1'b1; l_addr = 32'h30;
      #1;
      chk("t3_fwd_inflight", l_data,              32'h111);
      chk("t3_req",          {31'd0, mem_wr_req}, 32'd1);
      chk("t3_waddr",        mem_wr_addr,         32'h30);
      l_addr = 32'h20;
      #1 chk("t3_fwd_youngest", l_data, 32'h2);
      l_addr = 32'h24;
      #1 chk("t3_nomatch", l_data, 32'h24 ^ MEM_KEY);
      load_en = 1'b0; l_addr = 32'h20;
      #1 chk("t3_load_off", l_data, 32'h20 ^ MEM_KEY);
      @(negedge clk);
      store_en = 1'b1; s_addr = 32'h20; s_data = 32'h3; load_en = 1'b1;
      #1;
      chk("t3_same_cycle", l_data,         32'h2);
      chk("t3_stall3",     {31'd0, stall}, 32'd0);
      @(negedge clk);
      store_en = 1'b0;
      #1 chk("t3_fwd_new", l_data, 32'h3);
      man_ack = 1'b1; l_addr = 32'h30;
      #1 chk("t3_fwd_acking", l_data, 32'h111);
      @(negedge clk);
      man_ack = 1'b0;
      #1;
      chk("t3_after_ack", l_data,              32'h30 ^ MEM_KEY);
      chk("t3_req_drop",  {31'd0, mem_wr_req}, 32'd0);
      chk("t3_nwr",       wq_addr.size(),      32'd1);
      @(negedge clk); #1;
      chk("t3_next_req",   {31'd0, mem_wr_req}, 32'd1);
      chk("t3_next_addr",  mem_wr_addr,         32'h20);
      chk("t3_next_data",  mem_wr_data,         32'h1);
      load_en = 1'b0;

      // Reset mid-BUSY with three entries, then stray ack
      wq_addr.delete(); wq_data.delete();
      rst = 1'b0; store_en = 1'b1; s_addr = 32'h50; s_data = 32'h5;
      #1;
      chk("t5_req_async", {31'd0, mem_wr_req}, 32'd0);
      chk("t5_empty",     {31'd0, empty},      32'd1);
      chk("t5_stall",     {31'd0, stall},      32'd0);
      chk("t5_waddr",     mem_wr_addr,         32'd0);
      chk("t5_wdata",     mem_wr_data,         32'd0);
      @(negedge clk); store_en = 1'b0;
      @(negedge clk); rst = 1'b1; man_ack = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("t5_stray_req",   {31'd0, mem_wr_req}, 32'd0);
      chk("t5_stray_empty", {31'd0, empty},      32'd1);
      man_ack = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("t5_idle_req", {31'd0, mem_wr_req}, 32'd0);
      chk("t5_nwr",      wq_addr.size(),      32'd0);

      // Pointer wrap: 10 stores with random ack delays
      ack_mode = 2;
      wq_addr.delete(); wq_data.delete();
      ws_i = 0; guard = 0;
      while (ws_i < 10 && guard < 200) begin
         @(negedge clk);
         store_en = 1'b1; s_addr = 32'h100 + W'(4 * ws_i); s_data = 32'hC0DE_0000 + W'(ws_i);
         #1;
         if (!stall) ws_i++;
         guard++;
      end
      @(negedge clk); store_en = 1'b0;
      guard = 0;
      #1;
      while (!empty && guard < 200) begin
         @(negedge clk); #1;
         guard++;
      end
      chk("t4_sent",    W'(ws_i),        32'd10);
      chk("t4_drained", {31'd0, empty},  32'd1);
      chk("t4_nwr",     wq_addr.size(),  32'd10);
      for (int i = 0; i < 10 && i < wq_addr.size(); i++) begin
         chk("t4_wrap_addr", wq_addr[i], 32'h100 + W'(4 * i));
         chk("t4_wrap_data", wq_data[i], 32'hC0DE_0000 + W'(i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
